// File: rtl/ip_lpm_prio_if.sv
// Lookup-path bundle for ip_lpm_prio: packet capture strobes, result to the
// ARP stage, route-table read/write access and statistics.
interface ip_lpm_prio_if #(
   parameter int DATA_WIDTH     = 64,
   parameter int NUM_QUEUES     = 8,
   parameter int LUT_DEPTH      = 32,
   parameter int LUT_DEPTH_BITS = $clog2(LUT_DEPTH)
) ();
   logic [DATA_WIDTH-1:0]     in_data;
   logic                      word_IP_SRC_DST;
   logic                      word_IP_DST_LO;

   logic [31:0]               lpm_next_hop_ip;
   logic [NUM_QUEUES-1:0]     lpm_output_port;
   logic                      lpm_vld;
   logic                      lpm_hit;

   logic [LUT_DEPTH_BITS-1:0] lpm_rd_addr;
   logic                      lpm_rd_req;
   logic [31:0]               lpm_rd_ip;
   logic [31:0]               lpm_rd_mask;
   logic [31:0]               lpm_rd_next_hop_ip;
   logic [NUM_QUEUES-1:0]     lpm_rd_oq;
   logic                      lpm_rd_valid;
   logic                      lpm_rd_ack;

   logic [LUT_DEPTH_BITS-1:0] lpm_wr_addr;
   logic                      lpm_wr_req;
   logic [31:0]               lpm_wr_ip;
   logic [31:0]               lpm_wr_mask;
   logic [31:0]               lpm_wr_next_hop_ip;
   logic [NUM_QUEUES-1:0]     lpm_wr_oq;
   logic                      lpm_wr_valid;
   logic                      lpm_wr_ack;

   logic [31:0]               lpm_hit_count;
   logic [31:0]               lpm_miss_count;
   logic [31:0]               lpm_drop_count;

   // Upstream / software side.
   modport master (
      output in_data, word_IP_SRC_DST, word_IP_DST_LO,
      input  lpm_next_hop_ip, lpm_output_port, lpm_vld, lpm_hit,
      output lpm_rd_addr, lpm_rd_req,
      input  lpm_rd_ip, lpm_rd_mask, lpm_rd_next_hop_ip, lpm_rd_oq, lpm_rd_valid, lpm_rd_ack,
      output lpm_wr_addr, lpm_wr_req, lpm_wr_ip, lpm_wr_mask, lpm_wr_next_hop_ip, lpm_wr_oq, lpm_wr_valid,
      input  lpm_wr_ack,
      input  lpm_hit_count, lpm_miss_count, lpm_drop_count
   );

   // LPM stage side.
   modport slave (
      input  in_data, word_IP_SRC_DST, word_IP_DST_LO,
      output lpm_next_hop_ip, lpm_output_port, lpm_vld, lpm_hit,
      input  lpm_rd_addr, lpm_rd_req,
      output lpm_rd_ip, lpm_rd_mask, lpm_rd_next_hop_ip, lpm_rd_oq, lpm_rd_valid, lpm_rd_ack,
      input  lpm_wr_addr, lpm_wr_req, lpm_wr_ip, lpm_wr_mask, lpm_wr_next_hop_ip, lpm_wr_oq, lpm_wr_valid,
      output lpm_wr_ack,
      output lpm_hit_count, lpm_miss_count, lpm_drop_count
   );
endinterface

// File: rtl/ip_lpm_prio.sv
// Longest-prefix-match stage: captures dst IP, queues lookups, scans a
// register-based route table one entry per cycle choosing the highest mask
// popcount (lowest address on ties), and reports the result to the ARP stage.
module ip_lpm_prio #(
   parameter int DATA_WIDTH     = 64,
   parameter int NUM_QUEUES     = 8,
   parameter int LUT_DEPTH      = 32,
   parameter int LUT_DEPTH_BITS = $clog2(LUT_DEPTH),
   parameter int REQ_FIFO_DEPTH = 4
) (
   input logic          clk,
   input logic          reset,
   ip_lpm_prio_if.slave bus
);

   localparam int FIFO_AW = $clog2(REQ_FIFO_DEPTH);
   localparam logic [LUT_DEPTH_BITS-1:0] LAST_IDX      = LUT_DEPTH_BITS'(LUT_DEPTH - 1);
   localparam logic [FIFO_AW:0]          FIFO_FULL_CNT = (FIFO_AW + 1)'(REQ_FIFO_DEPTH);

   typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

   // Mask popcount; non-contiguous masks simply count their set bits.
   function automatic logic [5:0] popcount32(input logic [31:0] m);
      logic [5:0] c;
      c = '0;
      for (int i = 0; i < 32; i++) c = c + {5'd0, m[i]};
      return c;
   endfunction

   // Statistics counters stick at all-ones instead of wrapping.
   function automatic logic [31:0] sat_inc(input logic [31:0] v);
      return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
   endfunction

   // ---------------- route table ----------------
   logic                      tbl_vld_q  [LUT_DEPTH];
   logic [31:0]               tbl_ip_q   [LUT_DEPTH];
   logic [31:0]               tbl_mask_q [LUT_DEPTH];
   logic [NUM_QUEUES-1:0]     tbl_oq_q   [LUT_DEPTH];
   logic [31:0]               tbl_nh_q   [LUT_DEPTH];
   logic [5:0]                tbl_plen_q [LUT_DEPTH];

   // ---------------- FSM / scan state ----------------
   state_t                    state_q;
   logic [31:0]               cur_ip_q;
   logic [LUT_DEPTH_BITS-1:0] idx_q;
   logic                      best_vld_q;
   logic [5:0]                best_plen_q;
   logic [NUM_QUEUES-1:0]     best_oq_q;
   logic [31:0]               best_nh_q;
   logic [31:0]               res_nh_q;
   logic [NUM_QUEUES-1:0]     res_port_q;
   logic                      res_vld_q;
   logic                      res_hit_q;
   logic                      wr_ack_q;
   logic [31:0]               hit_cnt_q;
   logic [31:0]               miss_cnt_q;

   // ---------------- destination capture ----------------
   logic [15:0] dst_hi_q, dst_hi_d;
   logic [31:0] lookup_ip;
   logic        unused_in_data;

   // Hold the upper half of dst_ip until the low word arrives.
   always_comb begin
      dst_hi_d  = bus.word_IP_SRC_DST ? bus.in_data[15:0] : dst_hi_q;
      lookup_ip = {dst_hi_q, bus.in_data[DATA_WIDTH-1 -: 16]};
   end

   assign unused_in_data = ^bus.in_data[DATA_WIDTH-17:16];

   // Register the captured upper half.
   always_ff @(posedge clk) begin
      if (reset) dst_hi_q <= '0;
      else       dst_hi_q <= dst_hi_d;
   end

   // ---------------- request FIFO ----------------
   logic [31:0]        fifo_mem_q [REQ_FIFO_DEPTH];
   logic [FIFO_AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [FIFO_AW:0]   cnt_q, cnt_d;
   logic [31:0]        drop_cnt_q, drop_cnt_d;
   logic               fifo_full, fifo_empty, fifo_push, fifo_pop, fifo_drop;
   logic               wr_pend_q, wr_pend_d;

   // Push/pop decisions; a full FIFO still accepts when a pop frees a slot.
   always_comb begin
      fifo_full  = (cnt_q == FIFO_FULL_CNT);
      fifo_empty = (cnt_q == '0);
      fifo_pop   = (state_q == IDLE) && !wr_pend_q && !fifo_empty;
      fifo_push  = bus.word_IP_DST_LO && (!fifo_full || fifo_pop);
      fifo_drop  = bus.word_IP_DST_LO && !fifo_push;
      wr_ptr_d   = fifo_push ? wr_ptr_q + FIFO_AW'(1) : wr_ptr_q;
      rd_ptr_d   = fifo_pop  ? rd_ptr_q + FIFO_AW'(1) : rd_ptr_q;
      cnt_d      = cnt_q;
      if (fifo_push && !fifo_pop)      cnt_d = cnt_q + (FIFO_AW + 1)'(1);
      else if (!fifo_push && fifo_pop) cnt_d = cnt_q - (FIFO_AW + 1)'(1);
      drop_cnt_d = fifo_drop ? sat_inc(drop_cnt_q) : drop_cnt_q;
   end

   // FIFO pointers, occupancy and drop statistic.
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         cnt_q      <= '0;
         drop_cnt_q <= '0;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         cnt_q      <= cnt_d;
         drop_cnt_q <= drop_cnt_d;
      end
   end

   // FIFO storage; contents are meaningless once the occupancy is cleared.
   always_ff @(posedge clk) begin
      if (fifo_push) fifo_mem_q[wr_ptr_q] <= lookup_ip;
   end

   // ---------------- pending write ----------------
   logic [LUT_DEPTH_BITS-1:0] wr_addr_q, wr_addr_d;
   logic [31:0]               wr_ip_q, wr_ip_d, wr_mask_q, wr_mask_d, wr_nh_q, wr_nh_d;
   logic [NUM_QUEUES-1:0]     wr_oq_q, wr_oq_d;
   logic                      wr_vld_q, wr_vld_d;
   logic                      wr_apply;

   // Latch one write at a time; it is retired only when the FSM sits in IDLE.
   always_comb begin
      wr_apply  = (state_q == IDLE) && wr_pend_q;
      wr_pend_d = wr_pend_q ? !wr_apply : bus.lpm_wr_req;
      wr_addr_d = wr_addr_q;
      wr_ip_d   = wr_ip_q;
      wr_mask_d = wr_mask_q;
      wr_nh_d   = wr_nh_q;
      wr_oq_d   = wr_oq_q;
      wr_vld_d  = wr_vld_q;
      if (!wr_pend_q && bus.lpm_wr_req) begin
         wr_addr_d = bus.lpm_wr_addr;
         wr_ip_d   = bus.lpm_wr_ip;
         wr_mask_d = bus.lpm_wr_mask;
         wr_nh_d   = bus.lpm_wr_next_hop_ip;
         wr_oq_d   = bus.lpm_wr_oq;
         wr_vld_d  = bus.lpm_wr_valid;
      end
   end

   // Pending write flag and fields.
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_pend_q <= 1'b0;
         wr_addr_q <= '0;
         wr_ip_q   <= '0;
         wr_mask_q <= '0;
         wr_nh_q   <= '0;
         wr_oq_q   <= '0;
         wr_vld_q  <= 1'b0;
      end else begin
         wr_pend_q <= wr_pend_d;
         wr_addr_q <= wr_addr_d;
         wr_ip_q   <= wr_ip_d;
         wr_mask_q <= wr_mask_d;
         wr_nh_q   <= wr_nh_d;
         wr_oq_q   <= wr_oq_d;
         wr_vld_q  <= wr_vld_d;
      end
   end

   // ---------------- read port ----------------
   logic                  rd_ack_q, rd_ack_d, rd_vld_q, rd_vld_d;
   logic [31:0]           rd_ip_q, rd_ip_d, rd_mask_q, rd_mask_d, rd_nh_q, rd_nh_d;
   logic [NUM_QUEUES-1:0] rd_oq_q, rd_oq_d;

   // Reads sample the table as it stands before this cycle's write.
   always_comb begin
      rd_ack_d  = bus.lpm_rd_req;
      rd_vld_d  = rd_vld_q;
      rd_ip_d   = rd_ip_q;
      rd_mask_d = rd_mask_q;
      rd_nh_d   = rd_nh_q;
      rd_oq_d   = rd_oq_q;
      if (bus.lpm_rd_req) begin
         rd_vld_d  = tbl_vld_q[bus.lpm_rd_addr];
         rd_ip_d   = tbl_ip_q[bus.lpm_rd_addr];
         rd_mask_d = tbl_mask_q[bus.lpm_rd_addr];
         rd_nh_d   = tbl_nh_q[bus.lpm_rd_addr];
         rd_oq_d   = tbl_oq_q[bus.lpm_rd_addr];
      end
   end

   // Read response registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         rd_ack_q  <= 1'b0;
         rd_vld_q  <= 1'b0;
         rd_ip_q   <= '0;
         rd_mask_q <= '0;
         rd_nh_q   <= '0;
         rd_oq_q   <= '0;
      end else begin
         rd_ack_q  <= rd_ack_d;
         rd_vld_q  <= rd_vld_d;
         rd_ip_q   <= rd_ip_d;
         rd_mask_q <= rd_mask_d;
         rd_nh_q   <= rd_nh_d;
         rd_oq_q   <= rd_oq_d;
      end
   end

   // ---------------- scan compare ----------------
   logic scan_match, scan_better;

   // Strictly-longer wins, so the first (lowest) address keeps a tie.
   always_comb begin
      scan_match  = tbl_vld_q[idx_q] &&
                    (((cur_ip_q ^ tbl_ip_q[idx_q]) & tbl_mask_q[idx_q]) == 32'd0);
      scan_better = scan_match && (!best_vld_q || (tbl_plen_q[idx_q] > best_plen_q));
   end

   // Lookup FSM: applies writes and starts lookups in IDLE, scans, then reports.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= IDLE;
         cur_ip_q    <= '0;
         idx_q       <= '0;
         best_vld_q  <= 1'b0;
         best_plen_q <= '0;
         best_oq_q   <= '0;
         best_nh_q   <= '0;
         res_nh_q    <= '0;
         res_port_q  <= '0;
         res_vld_q   <= 1'b0;
         res_hit_q   <= 1'b0;
         wr_ack_q    <= 1'b0;
         hit_cnt_q   <= '0;
         miss_cnt_q  <= '0;
         for (int i = 0; i < LUT_DEPTH; i++) begin
            tbl_vld_q[i]  <= 1'b0;
            tbl_ip_q[i]   <= '0;
            tbl_mask_q[i] <= '0;
            tbl_oq_q[i]   <= '0;
            tbl_nh_q[i]   <= '0;
            tbl_plen_q[i] <= '0;
         end
      end else begin
         res_vld_q <= 1'b0;
         wr_ack_q  <= 1'b0;
         case (state_q)
            IDLE: begin
               if (wr_pend_q) begin
                  tbl_vld_q[wr_addr_q]  <= wr_vld_q;
                  tbl_ip_q[wr_addr_q]   <= wr_ip_q;
                  tbl_mask_q[wr_addr_q] <= wr_mask_q;
                  tbl_oq_q[wr_addr_q]   <= wr_oq_q;
                  tbl_nh_q[wr_addr_q]   <= wr_nh_q;
                  tbl_plen_q[wr_addr_q] <= popcount32(wr_mask_q);
                  wr_ack_q              <= 1'b1;
               end else if (fifo_pop) begin
                  cur_ip_q   <= fifo_mem_q[rd_ptr_q];
                  best_vld_q <= 1'b0;
                  idx_q      <= '0;
                  state_q    <= SCAN;
               end
            end
            SCAN: begin
               if (scan_better) begin
                  best_vld_q  <= 1'b1;
                  best_plen_q <= tbl_plen_q[idx_q];
                  best_oq_q   <= tbl_oq_q[idx_q];
                  best_nh_q   <= tbl_nh_q[idx_q];
               end
               if (idx_q == LAST_IDX) state_q <= DONE;
               else                   idx_q   <= idx_q + LUT_DEPTH_BITS'(1);
            end
            DONE: begin
               res_vld_q <= 1'b1;
               res_hit_q <= best_vld_q;
               if (best_vld_q) begin
                  res_port_q <= best_oq_q;
                  res_nh_q   <= (best_nh_q == 32'd0) ? cur_ip_q : best_nh_q;
                  hit_cnt_q  <= sat_inc(hit_cnt_q);
               end else begin
                  res_port_q <= '0;
                  res_nh_q   <= cur_ip_q;
                  miss_cnt_q <= sat_inc(miss_cnt_q);
               end
               state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign bus.lpm_next_hop_ip    = res_nh_q;
   assign bus.lpm_output_port    = res_port_q;
   assign bus.lpm_vld            = res_vld_q;
   assign bus.lpm_hit            = res_hit_q;
   assign bus.lpm_rd_ip          = rd_ip_q;
   assign bus.lpm_rd_mask        = rd_mask_q;
   assign bus.lpm_rd_next_hop_ip = rd_nh_q;
   assign bus.lpm_rd_oq          = rd_oq_q;
   assign bus.lpm_rd_valid       = rd_vld_q;
   assign bus.lpm_rd_ack         = rd_ack_q;
   assign bus.lpm_wr_ack         = wr_ack_q;
   assign bus.lpm_hit_count      = hit_cnt_q;
   assign bus.lpm_miss_count     = miss_cnt_q;
   assign bus.lpm_drop_count     = drop_cnt_q;

endmodule

// File: tb/tb_ip_lpm_prio.sv
// Randomised scoreboard bench for ip_lpm_prio with a route-table reference model.
module tb_ip_lpm_prio;
   localparam int DW = 64, NQ = 8, LD = 32, LDB = 5, FD = 4;
   localparam int LATENCY = LD + 3;

   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   ip_lpm_prio_if #(.DATA_WIDTH(DW), .NUM_QUEUES(NQ), .LUT_DEPTH(LD), .LUT_DEPTH_BITS(LDB)) bus ();

   ip_lpm_prio #(.DATA_WIDTH(DW), .NUM_QUEUES(NQ), .LUT_DEPTH(LD), .LUT_DEPTH_BITS(LDB),
                 .REQ_FIFO_DEPTH(FD)) dut (.clk(clk), .reset(reset), .bus(bus));

   typedef struct {
      logic          hit;
      logic [NQ-1:0] port;
      logic [31:0]   nh;
   } exp_t;

   exp_t exp_q[$];
   int   vectors = 0, miscompares = 0;
   int   cyc = 0, lo_cyc = 0, vld_cnt = 0, last_vld_cyc = 0;
   int   m_hit = 0, m_miss = 0, m_drop = 0;

   logic          m_vld  [LD];
   logic [31:0]   m_ip   [LD];
   logic [31:0]   m_mask [LD];
   logic [31:0]   m_nh   [LD];
   logic [NQ-1:0] m_oq   [LD];

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
      vectors++;
      if (act !== req) begin
         miscompares++;
         $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   // ---------------- reference model ----------------
   function automatic bit model_match(input int a, input logic [31:0] ip);
      return m_vld[a] && (((ip ^ m_ip[a]) & m_mask[a]) == 32'd0);
   endfunction

   // Longest = most mask bits; among equals the lowest address.
   function automatic exp_t model_lookup(input logic [31:0] ip);
      exp_t r;
      int best_len = -1, best_a = -1;
      for (int a = 0; a < LD; a++)
         if (model_match(a, ip) && $countones(m_mask[a]) > best_len) best_len = $countones(m_mask[a]);
      for (int a = LD - 1; a >= 0; a--)
         if (model_match(a, ip) && $countones(m_mask[a]) == best_len) best_a = a;
      if (best_a < 0) begin
         r.hit = 1'b0; r.port = '0; r.nh = ip;
      end else begin
         r.hit = 1'b1; r.port = m_oq[best_a]; r.nh = (m_nh[best_a] == 32'd0) ? ip : m_nh[best_a];
      end
      return r;
   endfunction

   task automatic expect_lookup(input logic [31:0] ip);
      exp_t e;
      e = model_lookup(ip);
      if (e.hit) m_hit++; else m_miss++;
      exp_q.push_back(e);
   endtask

   task automatic model_clear();
      for (int a = 0; a < LD; a++) begin
         m_vld[a] = 1'b0; m_ip[a] = '0; m_mask[a] = '0; m_nh[a] = '0; m_oq[a] = '0;
      end
      m_hit = 0; m_miss = 0; m_drop = 0;
   endtask

   // ---------------- monitor ----------------
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (!reset && bus.lpm_vld) begin
            vld_cnt++;
            last_vld_cyc = cyc;
            if (exp_q.size() == 0) begin
               vectors++; miscompares++;
               $display("FAIL unexpected_result: vld with hit=%0b port=%0h nh=%0h, required no result", bus.lpm_hit, bus.lpm_output_port, bus.lpm_next_hop_ip);
            end else begin
               e = exp_q.pop_front();
               check("result{hit,port,nh}", {bus.lpm_hit, bus.lpm_output_port, bus.lpm_next_hop_ip}, {e.hit, e.port, e.nh});
            end
         end
      end
   end

   // ---------------- drivers ----------------
   task automatic bus_idle();
      @(posedge clk); #1;
      bus.word_IP_SRC_DST = 1'b0; bus.word_IP_DST_LO = 1'b0;
      bus.lpm_wr_req = 1'b0; bus.lpm_rd_req = 1'b0;
   endtask

   task automatic drive_hi(input logic [15:0] hi);
      @(posedge clk); #1;
      bus.in_data = {$urandom, $urandom};
      bus.in_data[15:0] = hi;
      bus.word_IP_SRC_DST = 1'b1; bus.word_IP_DST_LO = 1'b0;
   endtask

   task automatic drive_lo(input logic [15:0] lo);
      @(posedge clk); #1;
      bus.in_data = {$urandom, $urandom};
      bus.in_data[DW-1 -: 16] = lo;
      bus.word_IP_SRC_DST = 1'b0; bus.word_IP_DST_LO = 1'b1;
      lo_cyc = cyc;
   endtask

   task automatic lookup(input logic [31:0] ip);
      drive_hi(ip[31:16]);
      drive_lo(ip[15:0]);
      expect_lookup(ip);
      bus_idle();
   endtask

   task automatic issue_write(input int a, input logic [31:0] ip, input logic [31:0] mask,
                              input logic [31:0] nh, input logic [NQ-1:0] oq, input logic v);
      @(posedge clk); #1;
      bus.word_IP_SRC_DST = 1'b0; bus.word_IP_DST_LO = 1'b0;
      bus.lpm_wr_addr = LDB'(a); bus.lpm_wr_ip = ip; bus.lpm_wr_mask = mask;
      bus.lpm_wr_next_hop_ip = nh; bus.lpm_wr_oq = oq; bus.lpm_wr_valid = v;
      bus.lpm_wr_req = 1'b1;
      @(posedge clk); #1;
      bus.lpm_wr_req = 1'b0;
   endtask

   task automatic model_write(input int a, input logic [31:0] ip, input logic [31:0] mask,
                              input logic [31:0] nh, input logic [NQ-1:0] oq, input logic v);
      m_vld[a] = v; m_ip[a] = ip; m_mask[a] = mask; m_nh[a] = nh; m_oq[a] = oq;
   endtask

   task automatic wait_ack(output int ack_cyc);
      bit seen = 1'b0;
      ack_cyc = -1;
      for (int i = 0; i < 200 && !seen; i++) begin
         @(negedge clk);
         if (bus.lpm_wr_ack) begin seen = 1'b1; ack_cyc = cyc; end
      end
      check("wr_ack_arrived", 128'(seen), 128'(1));
   endtask

   task automatic write_entry(input int a, input logic [31:0] ip, input logic [31:0] mask,
                              input logic [31:0] nh, input logic [NQ-1:0] oq, input logic v);
      int c;
      issue_write(a, ip, mask, nh, oq, v);
      model_write(a, ip, mask, nh, oq, v);
      wait_ack(c);
   endtask

   task automatic read_check(input int a, input logic v, input logic [31:0] ip, input logic [31:0] mask,
                             input logic [31:0] nh, input logic [NQ-1:0] oq);
      @(posedge clk); #1;
      bus.lpm_rd_addr = LDB'(a); bus.lpm_rd_req = 1'b1;
      @(posedge clk); #1;
      bus.lpm_rd_req = 1'b0;
      @(negedge clk);
      check($sformatf("read[%0d]{ack,v,ip,mask,nh,oq}", a),
            {bus.lpm_rd_ack, bus.lpm_rd_valid, bus.lpm_rd_ip, bus.lpm_rd_mask, bus.lpm_rd_next_hop_ip, bus.lpm_rd_oq},
            {1'b1, v, ip, mask, nh, oq});
   endtask

   task automatic drain();
      int n = 0;
      while (exp_q.size() != 0 && n < 400) begin
         @(negedge clk);
         n++;
      end
      if (exp_q.size() != 0) begin
         vectors++; miscompares++;
         $display("FAIL drain_timeout: %0d results outstanding, required 0", exp_q.size());
         exp_q.delete();
      end
      @(negedge clk);
   endtask

   task automatic check_counters(input string tag);
      check({tag, "_hit_count"},  bus.lpm_hit_count,  128'(m_hit));
      check({tag, "_miss_count"}, bus.lpm_miss_count, 128'(m_miss));
      check({tag, "_drop_count"}, bus.lpm_drop_count, 128'(m_drop));
   endtask

   task automatic do_reset();
      @(posedge clk); #1;
      reset = 1'b1;
      bus.word_IP_SRC_DST = 1'b0; bus.word_IP_DST_LO = 1'b0;
      bus.lpm_wr_req = 1'b0; bus.lpm_rd_req = 1'b0;
      exp_q.delete();
      model_clear();
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
   endtask

   function automatic logic [31:0] plen_mask(input int len);
      return (len == 0) ? 32'd0 : (32'hFFFF_FFFF << (32 - len));
   endfunction

   // ---------------- stimulus ----------------
   initial begin
      exp_t ea, eb;
      int   base, ack_c;
      logic [31:0] ip;

      bus.in_data = '0; bus.word_IP_SRC_DST = 1'b0; bus.word_IP_DST_LO = 1'b0;
      bus.lpm_rd_addr = '0; bus.lpm_rd_req = 1'b0;
      bus.lpm_wr_addr = '0; bus.lpm_wr_req = 1'b0; bus.lpm_wr_ip = '0; bus.lpm_wr_mask = '0;
      bus.lpm_wr_next_hop_ip = '0; bus.lpm_wr_oq = '0; bus.lpm_wr_valid = 1'b0;
      model_clear();
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;

      // Reset state.
      @(negedge clk);
      check("reset_result", {bus.lpm_vld, bus.lpm_hit, bus.lpm_output_port, bus.lpm_next_hop_ip}, 128'(0));
      check("reset_acks", {bus.lpm_wr_ack, bus.lpm_rd_ack}, 128'(0));
      check_counters("reset");
      read_check(0, 1'b0, '0, '0, '0, '0);
      read_check(31, 1'b0, '0, '0, '0, '0);

      // Empty table miss and latency.
      lookup(32'h0A00_0001);
      drain();
      check("miss_latency", 128'(last_vld_cyc - lo_cyc), 128'(LATENCY));
      check("miss_next_hop_literal", bus.lpm_next_hop_ip, 32'h0A00_0001);
      check_counters("empty");

      // Longer prefix at higher address wins.
      write_entry(0, 32'h0A00_0000, plen_mask(8),  32'h0,         8'h01, 1'b1);
      write_entry(5, 32'h0A01_0000, plen_mask(16), 32'h0A01_00FE, 8'h04, 1'b1);
      lookup(32'h0A01_0203);
      lookup(32'h0A02_0304);
      drain();
      repeat (5) @(negedge clk);
      check("result_hold", {bus.lpm_hit, bus.lpm_output_port, bus.lpm_next_hop_ip}, {1'b1, 8'h01, 32'h0A02_0304});
      check_counters("prefix");

      // Equal plen ties, default route, non-contiguous mask.
      write_entry(2,  32'hC0A8_0000, plen_mask(24), 32'h0, 8'h10, 1'b1);
      write_entry(7,  32'hC0A8_0000, plen_mask(24), 32'h0, 8'h20, 1'b1);
      write_entry(31, 32'h0,         32'h0,         32'h0, 8'h80, 1'b1);
      write_entry(12, 32'hAC00_0005, 32'hFF00_00FF, 32'hAC00_0001, 8'h08, 1'b1);
      read_check(12, 1'b1, 32'hAC00_0005, 32'hFF00_00FF, 32'hAC00_0001, 8'h08);
      lookup(32'hC0A8_004D);
      lookup(32'h0808_0808);
      lookup(32'hAC12_3405);
      drain();
      check_counters("ties");

      // Burst of six low words: four queue behind one in flight, sixth dropped.
      drive_hi(16'hC0A8);
      for (int i = 0; i < 6; i++) begin
         ip = {16'hC0A8, 8'(i % 2), 8'($urandom)};
         drive_lo(ip[15:0]);
         if (i < 5) expect_lookup(ip);
         else       m_drop++;
      end
      bus_idle();
      drain();
      check_counters("burst");

      // Write during a scan: held until IDLE, in-flight lookup sees old entry.
      base = vld_cnt;
      ea = model_lookup(32'h0A01_0203);
      drive_hi(16'h0A01);
      drive_lo(16'h0203);
      expect_lookup(32'h0A01_0203);
      issue_write(5, 32'h0A01_0000, plen_mask(16), 32'h0A01_01FE, 8'h02, 1'b1);
      read_check(5, 1'b1, 32'h0A01_0000, plen_mask(16), 32'h0A01_00FE, 8'h04);
      model_write(5, 32'h0A01_0000, plen_mask(16), 32'h0A01_01FE, 8'h02, 1'b1);
      eb = model_lookup(32'h0A01_0203);
      check("midscan_model_differs", 128'(ea.port != eb.port), 128'(1));
      lookup(32'h0A01_0203);
      wait_ack(ack_c);
      check("wr_ack_after_inflight_vld", 128'(vld_cnt - base), 128'(1));
      drain();
      read_check(5, 1'b1, 32'h0A01_0000, plen_mask(16), 32'h0A01_01FE, 8'h02);
      check_counters("midscan");

      // Randomised table contents and lookups.
      for (int round = 0; round < 3; round++) begin
         for (int k = 0; k < 6; k++) begin
            int a, len;
            logic [31:0] mask;
            a    = $urandom_range(0, LD - 1);
            len  = $urandom_range(0, 32);
            mask = ($urandom_range(0, 4) == 0) ? $urandom : plen_mask(len);
            write_entry(a, $urandom & mask, mask, ($urandom_range(0, 1) == 0) ? 32'h0 : $urandom,
                        NQ'(1) << $urandom_range(0, NQ - 1), $urandom_range(0, 7) != 0);
         end
         for (int b = 0; b < 4; b++) begin
            int burst;
            burst = $urandom_range(1, 3);
            for (int j = 0; j < burst; j++) begin
               int a;
               a = $urandom_range(0, LD - 1);
               if ($urandom_range(0, 3) == 0) ip = $urandom;
               else ip = (m_ip[a] & m_mask[a]) | ($urandom & ~m_mask[a]);
               lookup(ip);
            end
            drain();
         end
         check_counters($sformatf("random%0d", round));
      end

      // Reset in the middle of a scan.
      drive_hi(16'h0A01);
      drive_lo(16'h0203);
      bus_idle();
      repeat (8) @(posedge clk);
      do_reset();
      base = vld_cnt;
      repeat (60) @(negedge clk);
      check("no_vld_after_reset", 128'(vld_cnt), 128'(base));
      check_counters("postreset");
      read_check(0, 1'b0, '0, '0, '0, '0);
      read_check(5, 1'b0, '0, '0, '0, '0);
      read_check(31, 1'b0, '0, '0, '0, '0);
      lookup(32'h0A01_0203);
      drain();
      check("postreset_latency", 128'(last_vld_cyc - lo_cyc), 128'(LATENCY));
      check_counters("postreset_lookup");

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   // Global time bound.
   initial begin
      #2ms;
      $display("FAIL watchdog: simulation time limit reached, %0d results outstanding", exp_q.size());
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/ip_lpm_prio.md
Name: ip_lpm_prio

Overview:
- Next-generation LPM stage for the cam_router output_port_lookup path.
- Assembles the destination IPv4 address from the preprocess word strobes and queues the lookup.
- Finds the true longest-prefix match by scanning a parametrised, register-based route table, where longest means the highest mask popcount, not the lowest address.
- Drives next-hop IP, output port and hit/valid to the ARP stage, and keeps hit, miss and overflow statistics.

Parameters:
- DATA_WIDTH, 64: datapath word width.
- NUM_QUEUES, 8: output-port one-hot width.
- LUT_DEPTH, 32: route table entries.
- LUT_DEPTH_BITS, log2(LUT_DEPTH): table address width.
- REQ_FIFO_DEPTH, 4: pending-lookup queue depth, power of 2.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- in_data  in  DATA_WIDTH  packet word
- word_IP_SRC_DST  in  1  in_data[15:0] = dst_ip[31:16]
- word_IP_DST_LO  in  1  in_data[DATA_WIDTH-1:DATA_WIDTH-16] = dst_ip[15:0]; triggers lookup
- lpm_next_hop_ip  out  32  result next hop
- lpm_output_port  out  NUM_QUEUES  result port
- lpm_vld  out  1  one-cycle result strobe
- lpm_hit  out  1  result matched an entry
- lpm_rd_addr  in  LUT_DEPTH_BITS  read address
- lpm_rd_req  in  1  read pulse
- lpm_rd_ip / lpm_rd_mask / lpm_rd_next_hop_ip  out  32 each  entry fields
- lpm_rd_oq  out  NUM_QUEUES  entry port
- lpm_rd_valid  out  1  entry valid bit
- lpm_rd_ack  out  1  read done pulse
- lpm_wr_addr  in  LUT_DEPTH_BITS  write address
- lpm_wr_req  in  1  write pulse
- lpm_wr_ip / lpm_wr_mask / lpm_wr_next_hop_ip  in  32 each  entry fields
- lpm_wr_oq  in  NUM_QUEUES  entry port
- lpm_wr_valid  in  1  entry valid bit
- lpm_wr_ack  out  1  write done pulse
- lpm_hit_count / lpm_miss_count / lpm_drop_count  out  32 each  statistics

Behaviour:
- Reset (synchronous, active-high; clock clk):
  - All outputs are 0, all table entries are invalid and zero, the FIFO is emptied, all counters are 0, and the FSM goes to IDLE.
  - Reset in any state abandons the scan in progress and any pending write, with no ack.
- Table storage:
  - Each entry holds {valid, ip, mask, oq, next_hop, plen}.
  - plen (6 bits) is the popcount of the mask, computed at write time. Non-contiguous masks are legal; plen is still their popcount.
- Lookup capture:
  - Sampling word_IP_DST_LO completes dst_ip and pushes it into the FIFO on the next cycle.
  - If the FIFO is full, the request is dropped and lpm_drop_count increments. The counter saturates at 0xFFFFFFFF, as do all counters.
- FSM:
  - IDLE:
    - If a write is pending, apply it this cycle; lpm_wr_ack pulses the next cycle.
    - Otherwise, if the FIFO is non-empty, pop it into cur_ip, clear best_vld and idx, and go to SCAN.
  - SCAN:
    - One entry per cycle, idx = 0..LUT_DEPTH-1.
    - An entry matches when valid and ((cur_ip ^ ip) & mask) == 0.
    - On a match, update best when !best_vld or plen > best_plen. On equal plen the lower address wins.
    - After idx = LUT_DEPTH-1, go to DONE.
  - DONE:
    - Register the outputs, pulse lpm_vld for one cycle, increment the hit or miss counter, and return to IDLE.
- Result:
  - On a hit: lpm_hit = 1, lpm_output_port = best oq, and lpm_next_hop_ip = best next_hop, or cur_ip when next_hop == 0.
  - On a miss: lpm_hit = 0, lpm_output_port = 0, lpm_next_hop_ip = cur_ip.
  - The result output fields hold their values between strobes.
- Latency:
  - With the FIFO empty and the FSM in IDLE, lpm_vld asserts LUT_DEPTH+3 cycles after the cycle that sampled word_IP_DST_LO.
  - Results are strictly in request order.
  - Throughput is one lookup per LUT_DEPTH+2 cycles.
- Writes:
  - lpm_wr_req is latched into a pending flag with its fields. The write is applied only in IDLE, so it never changes the table during a scan.
  - Worst-case ack is LUT_DEPTH+3 cycles after the request.
  - A lpm_wr_req arriving while a write is already pending is ignored; software must wait for lpm_wr_ack.
- Reads:
  - Served from the table in any state; lpm_rd_ack and the data follow lpm_rd_req by 1 cycle.
  - A read of an address being written in the same cycle returns the old contents.
- Simultaneous events:
  - A FIFO push and pop in the same cycle keep the occupancy unchanged. A push to a full FIFO in the same cycle as a pop is accepted, not dropped.

Test Plan:
- Empty table, dst 10.0.0.1 → lpm_vld after LUT_DEPTH+3 cycles with hit=0, port=0, next_hop=0x0A000001; miss_count = 1.
- Entries: addr0 10.0.0.0/8 oq=0x01; addr5 10.1.0.0/16 oq=0x04, nh=10.1.0.254; lookup 10.1.2.3 → hit=1, port=0x04, next_hop=0x0A0100FE (longer prefix wins despite higher address).
- Equal plen: addr2 and addr7 both 192.168.0.0/24 with different oq → addr2's oq is returned; a default route 0/0 at addr31, valid=1, catches 8.8.8.8.
- Six back-to-back lookups with REQ_FIFO_DEPTH=4 → 5 results in order (4 queued + 1 in flight), drop_count = 1.
- lpm_wr_req issued mid-scan → wr_ack arrives only after that lookup's lpm_vld; the lookup uses the old entry, and the next lookup uses the new entry. A read during the scan returns the old entry after 1 cycle.
- Reset asserted mid-SCAN → no lpm_vld, all table entries invalid, counters 0; a following lookup misses.
